// File: rtl/nav_arb_if.sv
// Signal bundle shared by cmd_proc, maze_solve, navigate and the nav_arb arbiter.
interface nav_arb_if #(parameter int HDNG_W = 12);
  // Handshake: a source pulses *_strt_* for one cycle; the arbiter owns the request
  // from then on. It issues one strt_* pulse per request and holds stp_* / dsrd_hdng
  // until navigate pulses mv_cmplt for one cycle. The completion then goes back to the owner only.
  logic              cmd_md;
  logic              sol_cmplt;
  logic              c_strt_hdng, c_strt_mv, c_stp_lft, c_stp_rght;
  logic [HDNG_W-1:0] c_dsrd_hdng;
  logic              s_strt_hdng, s_strt_mv, s_stp_lft, s_stp_rght;
  logic [HDNG_W-1:0] s_dsrd_hdng;
  logic              mv_cmplt;
  logic              strt_hdng, strt_mv, stp_lft, stp_rght;
  logic [HDNG_W-1:0] dsrd_hdng;
  logic              c_mv_cmplt, s_mv_cmplt;
  logic              owner, busy, tmo;
  logic [1:0]        state_dbg;

  modport master (
    output cmd_md, sol_cmplt,
           c_strt_hdng, c_strt_mv, c_stp_lft, c_stp_rght, c_dsrd_hdng,
           s_strt_hdng, s_strt_mv, s_stp_lft, s_stp_rght, s_dsrd_hdng,
           mv_cmplt,
    input  strt_hdng, strt_mv, stp_lft, stp_rght, dsrd_hdng,
           c_mv_cmplt, s_mv_cmplt, owner, busy, tmo, state_dbg
  );

  modport slave (
    input  cmd_md, sol_cmplt,
           c_strt_hdng, c_strt_mv, c_stp_lft, c_stp_rght, c_dsrd_hdng,
           s_strt_hdng, s_strt_mv, s_stp_lft, s_stp_rght, s_dsrd_hdng,
           mv_cmplt,
    output strt_hdng, strt_mv, stp_lft, stp_rght, dsrd_hdng,
           c_mv_cmplt, s_mv_cmplt, owner, busy, tmo, state_dbg
  );
endinterface

// File: rtl/nav_arb.sv
// Registered arbiter sharing navigate between cmd_proc and maze_solve, with one
// request latch per source and a watchdog for moves that never complete.
module nav_arb #(
  parameter int          HDNG_W  = 12,
  parameter logic [23:0] TMO_CYC = 24'h80_0000
) (
  input logic      clk,
  input logic      rst,
  nav_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, BUSY = 2'd2} state_t;

  typedef struct packed {
    logic              full;
    logic              hdng;
    logic [HDNG_W-1:0] hd;
    logic              lft;
    logic              rght;
  } req_t;

  state_t            state_q, state_d;
  req_t              c_req_q, c_req_d, s_req_q, s_req_d, sel;
  logic              cmd_md_q;
  logic              grant_c, grant_s;
  logic              strt_hdng_q, strt_hdng_d, strt_mv_q, strt_mv_d;
  logic              stp_lft_q, stp_lft_d, stp_rght_q, stp_rght_d;
  logic [HDNG_W-1:0] dsrd_q, dsrd_d;
  logic              c_cmp_q, c_cmp_d, s_cmp_q, s_cmp_d;
  logic              owner_q, owner_d, busy_q, busy_d, tmo_q, tmo_d;
  logic [23:0]       cnt_q, cnt_d;

  // Newest pulse wins; a pulse in the consume cycle re-fills the latch.
  function automatic req_t next_req(input req_t cur, input logic consume,
                                    input logic p_hdng, input logic p_mv,
                                    input logic lft, input logic rght,
                                    input logic [HDNG_W-1:0] hd);
    req_t r;
    r = cur;
    if (consume) r.full = 1'b0;
    if (p_hdng || p_mv) begin
      r.full = 1'b1;
      r.hdng = p_hdng;
      r.hd   = p_hdng ? hd : cur.hd;
      r.lft  = p_hdng ? 1'b0 : lft;
      r.rght = p_hdng ? 1'b0 : rght;
    end
    return r;
  endfunction

  always_comb begin
    c_req_d = next_req(c_req_q, grant_c, bus.c_strt_hdng, bus.c_strt_mv,
                       bus.c_stp_lft, bus.c_stp_rght, bus.c_dsrd_hdng);
    s_req_d = next_req(s_req_q, grant_s, bus.s_strt_hdng, bus.s_strt_mv,
                       bus.s_stp_lft, bus.s_stp_rght, bus.s_dsrd_hdng);
    if (bus.sol_cmplt) s_req_d.full = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    grant_c     = 1'b0;
    grant_s     = 1'b0;
    sel         = c_req_q;
    owner_d     = owner_q;
    strt_hdng_d = 1'b0;
    strt_mv_d   = 1'b0;
    stp_lft_d   = stp_lft_q;
    stp_rght_d  = stp_rght_q;
    dsrd_d      = dsrd_q;
    c_cmp_d     = 1'b0;
    s_cmp_d     = 1'b0;
    busy_d      = busy_q;
    tmo_d       = tmo_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (c_req_q.full) begin
          grant_c = 1'b1;
          sel     = c_req_q;
          owner_d = 1'b0;
        end else if (s_req_q.full && !cmd_md_q && !bus.sol_cmplt) begin
          grant_s = 1'b1;
          sel     = s_req_q;
          owner_d = 1'b1;
        end
        // Issue outputs are registered here so they appear during the ISSUE cycle.
        if (grant_c || grant_s) begin
          state_d     = ISSUE;
          strt_hdng_d = sel.hdng;
          strt_mv_d   = !sel.hdng;
          if (sel.hdng) dsrd_d = sel.hd;
          stp_lft_d   = sel.lft;
          stp_rght_d  = sel.rght;
          busy_d      = 1'b1;
          tmo_d       = 1'b0;
          cnt_d       = '0;
        end
      end
      ISSUE: begin
        state_d = BUSY;
        cnt_d   = '0;
      end
      BUSY: begin
        if (bus.mv_cmplt) begin
          state_d    = IDLE;
          c_cmp_d    = !owner_q;
          s_cmp_d    = owner_q;
          stp_lft_d  = 1'b0;
          stp_rght_d = 1'b0;
          busy_d     = 1'b0;
        end else if (cnt_q >= TMO_CYC - 24'd1) begin
          state_d    = IDLE;
          tmo_d      = 1'b1;
          stp_lft_d  = 1'b0;
          stp_rght_d = 1'b0;
          busy_d     = 1'b0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_req_q     <= '0;
      s_req_q     <= '0;
      cmd_md_q    <= 1'b0;
      strt_hdng_q <= 1'b0;
      strt_mv_q   <= 1'b0;
      stp_lft_q   <= 1'b0;
      stp_rght_q  <= 1'b0;
      dsrd_q      <= '0;
      c_cmp_q     <= 1'b0;
      s_cmp_q     <= 1'b0;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
      tmo_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      c_req_q     <= c_req_d;
      s_req_q     <= s_req_d;
      cmd_md_q    <= bus.cmd_md;
      strt_hdng_q <= strt_hdng_d;
      strt_mv_q   <= strt_mv_d;
      stp_lft_q   <= stp_lft_d;
      stp_rght_q  <= stp_rght_d;
      dsrd_q      <= dsrd_d;
      c_cmp_q     <= c_cmp_d;
      s_cmp_q     <= s_cmp_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      tmo_q       <= tmo_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.strt_hdng  = strt_hdng_q;
  assign bus.strt_mv    = strt_mv_q;
  assign bus.stp_lft    = stp_lft_q;
  assign bus.stp_rght   = stp_rght_q;
  assign bus.dsrd_hdng  = dsrd_q;
  assign bus.c_mv_cmplt = c_cmp_q;
  assign bus.s_mv_cmplt = s_cmp_q;
  assign bus.owner      = owner_q;
  assign bus.busy       = busy_q;
  assign bus.tmo        = tmo_q;
  assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_nav_arb.sv
// Self-checking bench for nav_arb: issue records and completions go through expected queues.
module tb_nav_arb;
  localparam int          HDNG_W = 12;
  localparam logic [23:0] TMO    = 24'd16;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  logic [HDNG_W-1:0] model_hdng = '0;

  // issue record: {strt_hdng, strt_mv, dsrd_hdng, stp_lft, stp_rght, owner}
  logic [16:0] exp_q[$];
  // completion record: {c_mv_cmplt, s_mv_cmplt}
  logic [1:0]  exp_c_q[$];

  nav_arb_if #(.HDNG_W(HDNG_W)) bus ();

  nav_arb #(.HDNG_W(HDNG_W), .TMO_CYC(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_issue(input logic h, input logic m, input logic [HDNG_W-1:0] d,
                              input logic l, input logic r, input logic o);
    if (h) model_hdng = d;
    exp_q.push_back({h, m, model_hdng, l, r, o});
  endtask

  task automatic pulse_mv_cmplt(input logic own);
    bus.mv_cmplt = 1'b1;
    exp_c_q.push_back(own ? 2'b01 : 2'b10);
    step();
    bus.mv_cmplt = 1'b0;
  endtask

  task automatic monitor();
    logic [16:0] obs, exp;
    logic [1:0]  cobs, cexp;
    forever begin
      @(negedge clk);
      if (!rst && (bus.strt_hdng || bus.strt_mv)) begin
        obs = {bus.strt_hdng, bus.strt_mv, bus.dsrd_hdng, bus.stp_lft, bus.stp_rght, bus.owner};
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL issue_unexpected got=%h exp=none", obs);
        end else begin
          exp = exp_q.pop_front();
          if (obs !== exp) begin
            miscompares++;
            $display("FAIL issue_record got=%h exp=%h", obs, exp);
          end
        end
      end
      if (!rst && (bus.c_mv_cmplt || bus.s_mv_cmplt)) begin
        cobs = {bus.c_mv_cmplt, bus.s_mv_cmplt};
        vectors++;
        if (exp_c_q.size() == 0) begin
          miscompares++;
          $display("FAIL cmplt_unexpected got=%b exp=none", cobs);
        end else begin
          cexp = exp_c_q.pop_front();
          if (cobs !== cexp) begin
            miscompares++;
            $display("FAIL cmplt_route got=%b exp=%b", cobs, cexp);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [22:0] outs;
    rst = 1'b1;
    repeat (3) step();
    outs = {bus.strt_hdng, bus.strt_mv, bus.stp_lft, bus.stp_rght, bus.dsrd_hdng,
            bus.c_mv_cmplt, bus.s_mv_cmplt, bus.owner, bus.busy, bus.tmo, bus.state_dbg};
    vectors++;
    if (outs !== '0) begin miscompares++; $display("FAIL reset_outputs got=%h exp=0", outs); end
    rst = 1'b0;
    step();
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_cmd_heading();
    bus.cmd_md = 1'b1;
    bus.c_strt_hdng = 1'b1;
    bus.c_dsrd_hdng = 12'h3FF;
    expect_issue(1'b1, 1'b0, 12'h3FF, 1'b0, 1'b0, 1'b0);
    step();
    bus.c_strt_hdng = 1'b0;
    vectors++;
    if ({bus.strt_hdng, bus.busy} !== 2'b00) begin
      miscompares++; $display("FAIL hdng_cycle1 got=%b exp=00", {bus.strt_hdng, bus.busy});
    end
    step();
    vectors++;
    if ({bus.strt_hdng, bus.dsrd_hdng, bus.owner, bus.busy} !== {1'b1, 12'h3FF, 1'b0, 1'b1}) begin
      miscompares++; $display("FAIL hdng_cycle2 strt=%b hdng=%h owner=%b busy=%b", bus.strt_hdng,
                              bus.dsrd_hdng, bus.owner, bus.busy);
    end
    step();
    vectors++;
    if (bus.strt_hdng !== 1'b0) begin miscompares++; $display("FAIL hdng_pulse_width got=%b exp=0", bus.strt_hdng); end
    repeat (9) step();
    pulse_mv_cmplt(1'b0);
    vectors++;
    if ({bus.c_mv_cmplt, bus.s_mv_cmplt, bus.busy} !== 3'b100) begin
      miscompares++; $display("FAIL hdng_cmplt got=%b exp=100", {bus.c_mv_cmplt, bus.s_mv_cmplt, bus.busy});
    end
    step();
    vectors++;
    if (bus.c_mv_cmplt !== 1'b0) begin miscompares++; $display("FAIL hdng_cmplt_width got=%b exp=0", bus.c_mv_cmplt); end
  endtask

  task automatic test_simultaneous();
    bus.cmd_md = 1'b0;
    bus.c_strt_mv = 1'b1;
    bus.c_stp_lft = 1'b1;
    bus.s_strt_hdng = 1'b1;
    bus.s_dsrd_hdng = 12'h7FF;
    expect_issue(1'b0, 1'b1, 12'h000, 1'b1, 1'b0, 1'b0);
    expect_issue(1'b1, 1'b0, 12'h7FF, 1'b0, 1'b0, 1'b1);
    step();
    bus.c_strt_mv = 1'b0;
    bus.c_stp_lft = 1'b0;
    bus.s_strt_hdng = 1'b0;
    step();
    vectors++;
    if ({bus.strt_mv, bus.stp_lft, bus.owner} !== 3'b110) begin
      miscompares++; $display("FAIL simul_cmd_first got=%b exp=110", {bus.strt_mv, bus.stp_lft, bus.owner});
    end
    repeat (3) step();
    pulse_mv_cmplt(1'b0);
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL simul_gap busy got=%b exp=0", bus.busy); end
    step();
    vectors++;
    if ({bus.strt_hdng, bus.dsrd_hdng, bus.owner, bus.stp_lft} !== {1'b1, 12'h7FF, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL simul_sol_issue strt=%b hdng=%h owner=%b lft=%b", bus.strt_hdng,
                              bus.dsrd_hdng, bus.owner, bus.stp_lft);
    end
    repeat (2) step();
    pulse_mv_cmplt(1'b1);
    vectors++;
    if ({bus.c_mv_cmplt, bus.s_mv_cmplt} !== 2'b01) begin
      miscompares++; $display("FAIL simul_sol_cmplt got=%b exp=01", {bus.c_mv_cmplt, bus.s_mv_cmplt});
    end
    step();
  endtask

  task automatic test_mode_gating();
    bus.cmd_md = 1'b1;
    step();
    bus.s_strt_hdng = 1'b1;
    bus.s_dsrd_hdng = 12'h123;
    step();
    bus.s_strt_hdng = 1'b0;
    repeat (4) step();
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL gate_cmd_md busy got=%b exp=0", bus.busy); end
    bus.cmd_md = 1'b0;
    expect_issue(1'b1, 1'b0, 12'h123, 1'b0, 1'b0, 1'b1);
    step();
    vectors++;
    if (bus.strt_hdng !== 1'b0) begin miscompares++; $display("FAIL gate_early got=%b exp=0", bus.strt_hdng); end
    step();
    vectors++;
    if ({bus.strt_hdng, bus.owner} !== 2'b11) begin
      miscompares++; $display("FAIL gate_release got=%b exp=11", {bus.strt_hdng, bus.owner});
    end
    repeat (2) step();
    pulse_mv_cmplt(1'b1);
    step();
    // flush a pending solver request before the mode drops
    bus.cmd_md = 1'b1;
    step();
    bus.s_strt_hdng = 1'b1;
    bus.s_dsrd_hdng = 12'h456;
    step();
    bus.s_strt_hdng = 1'b0;
    bus.sol_cmplt = 1'b1;
    step();
    bus.sol_cmplt = 1'b0;
    bus.cmd_md = 1'b0;
    repeat (6) step();
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL flush_pending busy got=%b exp=0", bus.busy); end
    bus.s_strt_hdng = 1'b1;
    bus.sol_cmplt = 1'b1;
    step();
    bus.s_strt_hdng = 1'b0;
    bus.sol_cmplt = 1'b0;
    repeat (4) step();
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL flush_same_cycle busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_overwrite();
    bus.cmd_md = 1'b1;
    bus.c_strt_hdng = 1'b1;
    bus.c_dsrd_hdng = 12'h050;
    expect_issue(1'b1, 1'b0, 12'h050, 1'b0, 1'b0, 1'b0);
    step();
    bus.c_strt_hdng = 1'b0;
    repeat (2) step();
    bus.c_strt_hdng = 1'b1;
    bus.c_dsrd_hdng = 12'h100;
    step();
    bus.c_dsrd_hdng = 12'h200;
    step();
    bus.c_strt_hdng = 1'b0;
    expect_issue(1'b1, 1'b0, 12'h200, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (bus.dsrd_hdng !== 12'h050) begin miscompares++; $display("FAIL ovw_hold got=%h exp=050", bus.dsrd_hdng); end
    repeat (2) step();
    pulse_mv_cmplt(1'b0);
    step();
    vectors++;
    if ({bus.strt_hdng, bus.dsrd_hdng} !== {1'b1, 12'h200}) begin
      miscompares++; $display("FAIL ovw_newest strt=%b hdng=%h exp=1/200", bus.strt_hdng, bus.dsrd_hdng);
    end
    bus.c_strt_mv = 1'b1;
    bus.c_stp_rght = 1'b1;
    bus.c_dsrd_hdng = 12'hABC;
    expect_issue(1'b0, 1'b1, 12'h000, 1'b0, 1'b1, 1'b0);
    step();
    bus.c_strt_mv = 1'b0;
    bus.c_stp_rght = 1'b0;
    step();
    pulse_mv_cmplt(1'b0);
    step();
    vectors++;
    if ({bus.strt_mv, bus.dsrd_hdng, bus.stp_rght} !== {1'b1, 12'h200, 1'b1}) begin
      miscompares++; $display("FAIL ovw_mv_keeps strt=%b hdng=%h rght=%b", bus.strt_mv, bus.dsrd_hdng, bus.stp_rght);
    end
    step();
    pulse_mv_cmplt(1'b0);
    vectors++;
    if (bus.stp_rght !== 1'b0) begin miscompares++; $display("FAIL ovw_stp_drop got=%b exp=0", bus.stp_rght); end
    step();
  endtask

  task automatic test_watchdog();
    bus.cmd_md = 1'b1;
    bus.c_strt_hdng = 1'b1;
    bus.c_dsrd_hdng = 12'h0AA;
    expect_issue(1'b1, 1'b0, 12'h0AA, 1'b0, 1'b0, 1'b0);
    step();
    bus.c_strt_hdng = 1'b0;
    step();
    repeat (16) step();
    vectors++;
    if ({bus.tmo, bus.busy} !== 2'b01) begin
      miscompares++; $display("FAIL wd_early got=%b exp=01", {bus.tmo, bus.busy});
    end
    step();
    vectors++;
    if ({bus.tmo, bus.busy, bus.c_mv_cmplt} !== 3'b100) begin
      miscompares++; $display("FAIL wd_fire got=%b exp=100", {bus.tmo, bus.busy, bus.c_mv_cmplt});
    end
    bus.c_strt_mv = 1'b1;
    expect_issue(1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0);
    step();
    bus.c_strt_mv = 1'b0;
    step();
    vectors++;
    if ({bus.strt_mv, bus.tmo} !== 2'b10) begin
      miscompares++; $display("FAIL wd_clear got=%b exp=10", {bus.strt_mv, bus.tmo});
    end
    repeat (16) step();
    pulse_mv_cmplt(1'b0);
    vectors++;
    if ({bus.c_mv_cmplt, bus.tmo, bus.busy} !== 3'b100) begin
      miscompares++; $display("FAIL wd_tie got=%b exp=100", {bus.c_mv_cmplt, bus.tmo, bus.busy});
    end
    step();
  endtask

  task automatic test_reset_midop();
    logic [22:0] outs;
    bus.cmd_md = 1'b1;
    bus.c_strt_hdng = 1'b1;
    bus.c_dsrd_hdng = 12'h333;
    expect_issue(1'b1, 1'b0, 12'h333, 1'b0, 1'b0, 1'b0);
    step();
    bus.c_strt_hdng = 1'b0;
    repeat (2) step();
    bus.c_strt_mv = 1'b1;
    bus.c_stp_lft = 1'b1;
    bus.s_strt_hdng = 1'b1;
    bus.s_dsrd_hdng = 12'h444;
    step();
    bus.c_strt_mv = 1'b0;
    bus.c_stp_lft = 1'b0;
    bus.s_strt_hdng = 1'b0;
    rst = 1'b1;
    model_hdng = '0;
    step();
    rst = 1'b0;
    outs = {bus.strt_hdng, bus.strt_mv, bus.stp_lft, bus.stp_rght, bus.dsrd_hdng,
            bus.c_mv_cmplt, bus.s_mv_cmplt, bus.owner, bus.busy, bus.tmo, bus.state_dbg};
    vectors++;
    if (outs !== '0) begin miscompares++; $display("FAIL midop_reset got=%h exp=0", outs); end
    bus.mv_cmplt = 1'b1;
    step();
    bus.mv_cmplt = 1'b0;
    vectors++;
    if ({bus.c_mv_cmplt, bus.s_mv_cmplt} !== 2'b00) begin
      miscompares++; $display("FAIL midop_stray got=%b exp=00", {bus.c_mv_cmplt, bus.s_mv_cmplt});
    end
    repeat (4) step();
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL midop_latches busy got=%b exp=0", bus.busy); end
  endtask

  initial begin
    rst = 1'b1;
    bus.cmd_md = 1'b0;      bus.sol_cmplt = 1'b0;    bus.mv_cmplt = 1'b0;
    bus.c_strt_hdng = 1'b0; bus.c_strt_mv = 1'b0;    bus.c_stp_lft = 1'b0;
    bus.c_stp_rght = 1'b0;  bus.c_dsrd_hdng = '0;
    bus.s_strt_hdng = 1'b0; bus.s_strt_mv = 1'b0;    bus.s_stp_lft = 1'b0;
    bus.s_stp_rght = 1'b0;  bus.s_dsrd_hdng = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_cmd_heading();
    test_simultaneous();
    test_mode_gating();
    test_overwrite();
    test_watchdog();
    test_reset_midop();
    repeat (3) step();
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL issue_missing left=%0d exp=0", exp_q.size()); end
    vectors++;
    if (exp_c_q.size() != 0) begin miscompares++; $display("FAIL cmplt_missing left=%0d exp=0", exp_c_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/nav_arb.md
# nav_arb

Sequences and shares the single `navigate` unit between its two command sources: `cmd_proc` (command mode) and `maze_solve` (solver mode). It replaces the combinational `cmd_md` mux with a registered arbiter. Each source gets a one-entry request latch, and the arbiter issues one move or heading command at a time. It returns `mv_cmplt` only to the owner, and a watchdog recovers from moves that never complete.

## Interface
Parameters:
- `HDNG_W`, 12, width of desired heading.
- `TMO_CYC`, 24'h80_0000, watchdog limit in clocks for an issued command.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_md`  in  1  1 = command mode; 0 = solver requests eligible.
- `sol_cmplt`  in  1  magnet found; flushes the solver latch.
- `c_strt_hdng`, `c_strt_mv`  in  1 each  cmd_proc request pulses.
- `c_stp_lft`, `c_stp_rght`  in  1 each  cmd_proc stop qualifiers, sampled with `c_strt_mv`.
- `c_dsrd_hdng`  in  HDNG_W  cmd_proc heading, sampled with `c_strt_hdng`.
- `s_strt_hdng`, `s_strt_mv`, `s_stp_lft`, `s_stp_rght`, `s_dsrd_hdng`  in  same widths  maze_solve equivalents.
- `mv_cmplt`  in  1  completion pulse from navigate.
- `strt_hdng`, `strt_mv`  out  1 each  one-cycle issue pulses to navigate.
- `stp_lft`, `stp_rght`  out  1 each  held for the whole command.
- `dsrd_hdng`  out  HDNG_W  heading to navigate/IR_math; holds its last value.
- `c_mv_cmplt`, `s_mv_cmplt`  out  1 each  routed completion pulses.
- `owner`  out  1  0 = cmd_proc, 1 = solver; valid while busy.
- `busy`  out  1  command outstanding at navigate.
- `tmo`  out  1  sticky watchdog flag; cleared on the next issue.

## Operation
- **Latches.** Each source has one latch: full bit, type (hdng/mv), heading, and stp bits.
  - A `*_strt_hdng` or `*_strt_mv` pulse loads the latch. If both are high in the same cycle, type = hdng and stp bits are 0.
  - A heading is captured only for hdng-type requests. An mv-type request keeps the previously issued `dsrd_hdng`.
  - A pulse arriving while the latch is full overwrites it; the newest request wins.
  - A pulse arriving in the same cycle the latch is consumed is captured, so the latch stays full.
- **Eligibility.**
  - The cmd latch is always eligible.
  - The solver latch is eligible only when `cmd_md` = 0.
  - If both are eligible, cmd wins.
  - `sol_cmplt` = 1 clears the solver latch every cycle it is high. This takes precedence over a simultaneous solver pulse.
- **State machine.**
  - IDLE: if an eligible latch is full, grant it, set `owner`, and go to ISSUE.
  - ISSUE (1 cycle): pulse `strt_hdng` or `strt_mv` per type, drive `dsrd_hdng` and `stp_*`, clear the granted latch, clear `tmo`, start the watchdog counter at 0. Next state is BUSY.
  - BUSY:
    - On `mv_cmplt` = 1: pulse the owner's `*_mv_cmplt` next cycle, drop `stp_*`, go to IDLE.
    - Else if the counter reaches `TMO_CYC`-1: set `tmo`, go to IDLE, and issue no completion pulse.
    - If `mv_cmplt` and timeout coincide, `mv_cmplt` wins.
- `mv_cmplt` is ignored in IDLE and ISSUE.
- A `cmd_md` change while BUSY does not abort the command; the new mode applies only at the next grant.
- The watchdog counter is 24 bits and saturates; it never wraps.
- **Reset.** All outputs 0, `dsrd_hdng` 0, latches empty, state IDLE, counter 0. A reset mid-command discards both the command and the latches, with no completion pulse.

## Timing
- Request pulse in cycle 0 → latch full in cycle 1 → grant decision in cycle 1 → `strt_*` high in cycle 2 → `busy` = 1 from cycle 2.
- `dsrd_hdng` and `stp_*` change only in the ISSUE cycle. Both are stable for navigate and PID for the whole command.
- `mv_cmplt` in cycle M → `*_mv_cmplt` and `busy` = 0 in cycle M+1.
  - A queued latch issues its `strt_*` in cycle M+2.
  - This gives a minimum of 1 idle cycle between commands.
- Timeout: `tmo` rises `TMO_CYC`+1 cycles after the ISSUE cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Cmd heading.** Reset, `cmd_md`=1, pulse `c_strt_hdng` with `c_dsrd_hdng`=12'h3FF in cycle 0 → `strt_hdng`=1 only in cycle 2, `dsrd_hdng`=12'h3FF, `owner`=0. Then `mv_cmplt` in cycle 50 → `c_mv_cmplt`=1 in cycle 51 only, `s_mv_cmplt` stays 0.
- **Simultaneous requests.** `cmd_md`=0; pulse `c_strt_mv` (`c_stp_lft`=1) and `s_strt_hdng` (12'h7FF) in the same cycle → cmd issues first with `stp_lft`=1. After `mv_cmplt`, the solver `strt_hdng` issues 2 cycles later with `dsrd_hdng`=12'h7FF and `owner`=1.
- **Mode gating and flush.** `cmd_md`=1 with a solver request pending → no issue. Drop `cmd_md` → the solver request issues 2 cycles later. Repeat with `sol_cmplt` pulsed before `cmd_md` drops → no issue.
- **Overwrite and mv heading.** Two `c_strt_hdng` pulses (12'h100, then 12'h200) while busy → only 12'h200 issues. A following `c_strt_mv` keeps `dsrd_hdng`=12'h200.
- **Watchdog.** With `TMO_CYC`=16, no `mv_cmplt` → `tmo`=1 in ISSUE+17, `busy`=0, no completion pulse. The next issue clears `tmo`. `mv_cmplt` on the same cycle as the timeout → completion pulse and `tmo`=0.
- **Reset mid-op.** Assert `rst` for 1 cycle while busy with both latches full → next cycle all outputs 0. Stray `mv_cmplt` afterwards → no completion pulse.
